// File: rtl/aes_shift_rows_buf.sv
// Column-serial ShiftRows/InvShiftRows buffer feeding MixColumns.
// Define AES_SR_DOUBLE_BUF_EN for ping-pong banks; otherwise a single bank is used.
module aes_shift_rows_buf #(
    parameter int unsigned NUM_COLS = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] SR_IN,
    input  logic        SR_IN_VALID,
    output logic        SR_IN_READY,
    input  logic        SR_E_D,
    input  logic [3:0]  SR_COUNT_ROUND,
    output logic [31:0] SR_OUT,
    output logic        SR_OUT_VALID,
    input  logic        SR_OUT_READY,
    output logic        SR_OUT_LAST,
    output logic        SR_OUT_E_D,
    output logic [3:0]  SR_OUT_COUNT_ROUND
);

`ifdef AES_SR_DOUBLE_BUF_EN
    localparam bit DoubleBuf = 1'b1;
`else
    localparam bit DoubleBuf = 1'b0;
`endif
    localparam logic [1:0] LastCol = 2'(NUM_COLS - 1);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e      state_q;
    logic [31:0] mem_q [2][NUM_COLS];
    logic [1:0]  e_d_q;
    logic [3:0]  round_q [2];
    logic [1:0]  full_q;
    logic        wb_q, rb_q;
    logic [1:0]  wc_q, rc_q;

    logic        fill_hs, fill_done, drain_hs, drain_done, other_ready;
    logic [31:0] shifted;
    logic [1:0]  src;

    assign SR_IN_READY = !full_q[wb_q];
    assign fill_hs     = SR_IN_VALID && SR_IN_READY;
    assign fill_done   = fill_hs && (wc_q == LastCol);
    assign drain_hs    = SR_OUT_VALID && SR_OUT_READY;
    assign drain_done  = drain_hs && (rc_q == LastCol);
    // The other bank is (or is just becoming) full, so draining can continue without a bubble.
    assign other_ready = DoubleBuf && (full_q[~rb_q] || (fill_done && (wb_q != rb_q)));

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= StIdle;
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
            wc_q       <= '0;
            rc_q       <= '0;
            e_d_q      <= '0;
            round_q[0] <= '0;
            round_q[1] <= '0;
        end else begin
            if (fill_hs) begin
                wc_q <= wc_q + 2'd1;
                if (wc_q == 2'd0) begin
                    e_d_q[wb_q]   <= SR_E_D;
                    round_q[wb_q] <= SR_COUNT_ROUND;
                end
                if (fill_done) begin
                    full_q[wb_q] <= 1'b1;
                    wb_q         <= DoubleBuf ? ~wb_q : wb_q;
                end
            end
            if (drain_hs) begin
                rc_q <= rc_q + 2'd1;
                if (drain_done) begin
                    full_q[rb_q] <= 1'b0;
                    rb_q         <= DoubleBuf ? ~rb_q : rb_q;
                end
            end
            unique case (state_q)
                StIdle: begin
                    if (full_q[rb_q] || (fill_done && (wb_q == rb_q))) state_q <= StSend;
                end
                StSend: begin
                    if (drain_done && !other_ready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Data storage needs no reset: outputs are gated by SR_OUT_VALID.
    always_ff @(posedge CLK) begin
        if (fill_hs) mem_q[wb_q][wc_q] <= SR_IN;
    end

    always_comb begin
        shifted = '0;
        src     = '0;
        for (int r = 0; r < 4; r++) begin
            src = e_d_q[rb_q] ? (rc_q + 2'(r)) : (rc_q - 2'(r));
            shifted[31-8*r -: 8] = mem_q[rb_q][src][31-8*r -: 8];
        end
    end

    assign SR_OUT_VALID       = (state_q == StSend);
    assign SR_OUT             = SR_OUT_VALID ? shifted : '0;
    assign SR_OUT_LAST        = SR_OUT_VALID && (rc_q == LastCol);
    assign SR_OUT_E_D         = SR_OUT_VALID && e_d_q[rb_q];
    assign SR_OUT_COUNT_ROUND = SR_OUT_VALID ? round_q[rb_q] : '0;

endmodule

// File: tb/tb_aes_shift_rows_buf.sv
// Self-checking bench for aes_shift_rows_buf: directed vectors plus randomized blocks
// checked against a byte-matrix ShiftRows model.
module tb_aes_shift_rows_buf;

`ifdef AES_SR_DOUBLE_BUF_EN
    localparam bit DoubleBuf = 1'b1;
`else
    localparam bit DoubleBuf = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [31:0] SR_IN = '0;
    logic        SR_IN_VALID = 1'b0;
    logic        SR_IN_READY;
    logic        SR_E_D = 1'b0;
    logic [3:0]  SR_COUNT_ROUND = '0;
    logic [31:0] SR_OUT;
    logic        SR_OUT_VALID;
    logic        SR_OUT_READY = 1'b0;
    logic        SR_OUT_LAST;
    logic        SR_OUT_E_D;
    logic [3:0]  SR_OUT_COUNT_ROUND;

    aes_shift_rows_buf #(.NUM_COLS(4)) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .SR_IN             (SR_IN),
        .SR_IN_VALID       (SR_IN_VALID),
        .SR_IN_READY       (SR_IN_READY),
        .SR_E_D            (SR_E_D),
        .SR_COUNT_ROUND    (SR_COUNT_ROUND),
        .SR_OUT            (SR_OUT),
        .SR_OUT_VALID      (SR_OUT_VALID),
        .SR_OUT_READY      (SR_OUT_READY),
        .SR_OUT_LAST       (SR_OUT_LAST),
        .SR_OUT_E_D        (SR_OUT_E_D),
        .SR_OUT_COUNT_ROUND(SR_OUT_COUNT_ROUND)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] col;
        logic        last;
        logic        ed;
        logic [3:0]  rnd;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    logic [31:0] got_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          in_cnt = 0;
    int          cyc = 0;
    logic        held = 1'b0;
    logic [31:0] held_val = '0;
    logic [31:0] blk [4];
    logic [31:0] bp_blk [3][4];
    logic [31:0] req [8];
    bit          bp_done, rnd_done;
    int          start;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: treat the block as a 4x4 byte matrix and rotate each row by its index.
    task automatic push_block(input logic [31:0] cols [4], input logic ed, input logic [3:0] rnd);
        logic [7:0]  s [4][4];
        logic [31:0] w;
        int          k;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = cols[c][31-8*r -: 8];
        for (int c = 0; c < 4; c++) begin
            w = '0;
            for (int r = 0; r < 4; r++) begin
                k = ed ? (c + r) % 4 : (c - r + 4) % 4;
                w[31-8*r -: 8] = s[r][k];
            end
            exp_q.push_back('{col: w, last: (c == 3), ed: ed, rnd: rnd});
        end
    endtask

    task automatic send_col(input logic [31:0] d, input logic ed, input logic [3:0] rnd);
        int n = 0;
        SR_IN = d;
        SR_E_D = ed;
        SR_COUNT_ROUND = rnd;
        SR_IN_VALID = 1'b1;
        @(negedge CLK);
        while (!SR_IN_READY && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!SR_IN_READY) check_eq("in_ready_timeout", 32'(SR_IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        SR_IN_VALID = 1'b0;
    endtask

    // Columns 1..3 carry junk E_D/round that the DUT must ignore.
    task automatic send_block(input logic [31:0] cols [4], input logic ed, input logic [3:0] rnd);
        send_col(cols[0], ed, rnd);
        for (int c = 1; c < 4; c++) send_col(cols[c], 1'($urandom), 4'($urandom));
        push_block(cols, ed, rnd);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || SR_OUT_VALID) && n < 500) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check_eq("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (RST_N) begin
            if (held && SR_OUT_VALID) check_eq("hold_stable", SR_OUT, held_val);
            if (SR_OUT_VALID && SR_OUT_READY) begin
                check_eq("out_has_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_col", SR_OUT, e.col);
                    check_eq("out_last", 32'(SR_OUT_LAST), 32'(e.last));
                    check_eq("out_e_d", 32'(SR_OUT_E_D), 32'(e.ed));
                    check_eq("out_round", 32'(SR_OUT_COUNT_ROUND), 32'(e.rnd));
                end
                got_q.push_back(SR_OUT);
            end
            if (SR_IN_VALID && SR_IN_READY) in_cnt <= in_cnt + 1;
            held     <= SR_OUT_VALID && !SR_OUT_READY;
            held_val <= SR_OUT;
        end else begin
            held <= 1'b0;
        end
    end

    initial begin
        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_in_ready", 32'(SR_IN_READY), 32'd1);
        check_eq("rst_out_valid", 32'(SR_OUT_VALID), 32'd0);
        check_eq("rst_out", SR_OUT, 32'd0);
        check_eq("rst_last", 32'(SR_OUT_LAST), 32'd0);
        check_eq("rst_e_d", 32'(SR_OUT_E_D), 32'd0);
        check_eq("rst_round", 32'(SR_OUT_COUNT_ROUND), 32'd0);
        RST_N = 1'b1;
        SR_OUT_READY = 1'b1;
        @(posedge CLK);
        #1;
        check_eq("idle_out_valid", 32'(SR_OUT_VALID), 32'd0);

        // Encrypt, counting bytes; valid one cycle after column 3
        got_q.delete();
        blk = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
        send_block(blk, 1'b1, 4'd0);
        check_eq("latency_valid", 32'(SR_OUT_VALID), 32'd1);
        check_eq("latency_col0", SR_OUT, 32'h00050a0f);
        wait_drain();
        req[0:3] = '{32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b};
        check_eq("enc_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check_eq("enc_col", got_q[i], req[i]);

        // FIPS-197 round 1 then inverse, back to back
        got_q.delete();
        start = cyc;
        blk = '{32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
        send_block(blk, 1'b1, 4'd1);
        check_eq("fips_round", 32'(SR_OUT_COUNT_ROUND), 32'd1);
        check_eq("fips_e_d", 32'(SR_OUT_E_D), 32'd1);
        blk = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
        send_block(blk, 1'b0, 4'd9);
        check_eq("b2b_in_cycles", 32'(cyc - start), DoubleBuf ? 32'd8 : 32'd12);
        check_eq("inv_e_d", 32'(SR_OUT_E_D), 32'd0);
        check_eq("inv_col0", SR_OUT, 32'hd42711ae);
        wait_drain();
        req = '{32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5,
                32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230};
        check_eq("fips_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++) check_eq("fips_inv_col", got_q[i], req[i]);

        // Backpressure: three blocks with the output stalled
        got_q.delete();
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 4; c++) bp_blk[b][c] = $urandom;
        SR_OUT_READY = 1'b0;
        in_cnt = 0;
        bp_done = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) send_block(bp_blk[b], 1'($urandom), 4'($urandom));
                bp_done = 1'b1;
            end
        join_none
        repeat (12) @(posedge CLK);
        #1;
        check_eq("bp_in_cols", 32'(in_cnt), DoubleBuf ? 32'd8 : 32'd4);
        check_eq("bp_in_ready", 32'(SR_IN_READY), 32'd0);
        check_eq("bp_out_valid", 32'(SR_OUT_VALID), 32'd1);
        if (exp_q.size() != 0) check_eq("bp_out_col0", SR_OUT, exp_q[0].col);
        SR_OUT_READY = 1'b1;
        for (int n = 0; n < 200 && !bp_done; n++) @(posedge CLK);
        #1;
        check_eq("bp_fill_done", 32'(bp_done), 32'd1);
        wait_drain();
        check_eq("bp_count", 32'(got_q.size()), 32'd12);

        // Reset while block 1 drains (and block 2 is partly filled when double-buffered)
        for (int c = 0; c < 4; c++) blk[c] = $urandom;
        send_block(blk, 1'b1, 4'd3);
        if (DoubleBuf) begin
            send_col(32'h11111111, 1'b0, 4'd5);
            send_col(32'h22222222, 1'b0, 4'd5);
        end else begin
            @(posedge CLK);
            #1;
        end
        #2;
        RST_N = 1'b0;
        #1;
        check_eq("arst_out_valid", 32'(SR_OUT_VALID), 32'd0);
        check_eq("arst_in_ready", 32'(SR_IN_READY), 32'd1);
        exp_q.delete();
        got_q.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int c = 0; c < 4; c++) blk[c] = $urandom;
        send_block(blk, 1'b0, 4'd7);
        wait_drain();
        check_eq("post_rst_count", 32'(got_q.size()), 32'd4);

        // Randomized blocks with random gaps and random output stalls
        rnd_done = 1'b0;
        fork
            while (!rnd_done) begin
                @(posedge CLK);
                #1;
                SR_OUT_READY = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (int b = 0; b < 25; b++) begin
            for (int c = 0; c < 4; c++) blk[c] = $urandom;
            send_block(blk, 1'($urandom), 4'($urandom));
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end
        rnd_done = 1'b1;
        @(posedge CLK);
        #2;
        SR_OUT_READY = 1'b1;
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
